// File: rtl/snake_body_engine_if.sv
// Move/readout handshake and status bundle for snake_body_engine.
interface snake_body_engine_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7,
  parameter int unsigned LW = 5
);
  logic          step;
  logic [1:0]    dir;
  logic          grow;
  logic          rd_start;
  logic          rd_ready;
  logic          rd_valid;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;
  logic          rd_last;
  logic [LW-1:0] length;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          busy;
  logic          hit_wall;
  logic          hit_self;

  modport master (
    output step, dir, grow, rd_start, rd_ready,
    input  rd_valid, rd_x, rd_y, rd_last, length, head_x, head_y,
           busy, hit_wall, hit_self
  );

  modport slave (
    input  step, dir, grow, rd_start, rd_ready,
    output rd_valid, rd_x, rd_y, rd_last, length, head_x, head_y,
           busy, hit_wall, hit_self
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body store: shifts segments on each step, detects wall/self hits,
// and streams live segments out over a valid/ready handshake.
module snake_body_engine #(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 4,
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned CELL     = 10,
  parameter int unsigned XMAX     = 160,
  parameter int unsigned YMAX     = 120,
  parameter int unsigned X0       = 80,
  parameter int unsigned Y0       = 30
) (
  input  logic                CLOCK_50,
  input  logic                Resetn,
  snake_body_engine_if.slave  bus
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [XW-1:0] r_seg_x [MAX_LEN];
  logic [YW-1:0] r_seg_y [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [1:0]    r_heading;
  logic          r_grow;
  logic [IW-1:0] r_idx;
  logic          r_hit_wall;
  logic          r_hit_self;

  logic          w_fault;
  logic          w_idx_last;
  logic          w_match;
  logic [XW:0]   w_x_plus;
  logic [YW:0]   w_y_plus;
  logic [XW-1:0] w_cand_x;
  logic [YW-1:0] w_cand_y;
  logic          w_wall;

  logic          w_accept_step;
  logic          w_start_rd;
  logic          w_do_shift;
  logic          w_set_wall;
  logic          w_set_self;
  logic          w_idx_inc;

  assign w_fault    = r_hit_wall | r_hit_self;
  assign w_idx_last = (LW'(r_idx) == (r_len - LW'(1)));
  assign w_match    = (r_seg_x[r_idx] == r_seg_x[0]) && (r_seg_y[r_idx] == r_seg_y[0]);
  assign w_x_plus   = {1'b0, r_seg_x[0]} + (XW+1)'(CELL);
  assign w_y_plus   = {1'b0, r_seg_y[0]} + (YW+1)'(CELL);

  // Candidate head and wall test; left/up check before subtracting so there is no wrap.
  always_comb begin
    w_cand_x = r_seg_x[0];
    w_cand_y = r_seg_y[0];
    w_wall   = 1'b0;
    case (r_heading)
      2'd0: begin
        w_cand_x = w_x_plus[XW-1:0];
        w_wall   = (w_x_plus > (XW+1)'(XMAX - CELL));
      end
      2'd1: begin
        w_cand_y = w_y_plus[YW-1:0];
        w_wall   = (w_y_plus > (YW+1)'(YMAX - CELL));
      end
      2'd2: begin
        w_cand_y = r_seg_y[0] - YW'(CELL);
        w_wall   = (r_seg_y[0] < YW'(CELL));
      end
      default: begin
        w_cand_x = r_seg_x[0] - XW'(CELL);
        w_wall   = (r_seg_x[0] < XW'(CELL));
      end
    endcase
  end

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_fault) begin
          if (bus.step)          w_state_nxt = S_SHIFT;
          else if (bus.rd_start) w_state_nxt = S_READ;
        end
      end
      S_SHIFT: w_state_nxt = w_wall ? S_IDLE : S_CHECK;
      S_CHECK: if (w_match || w_idx_last) w_state_nxt = S_IDLE;
      S_READ:  if (bus.rd_ready && w_idx_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from state
  always_comb begin
    w_accept_step = 1'b0;
    w_start_rd    = 1'b0;
    w_do_shift    = 1'b0;
    w_set_wall    = 1'b0;
    w_set_self    = 1'b0;
    w_idx_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept_step = bus.step & ~w_fault;
        w_start_rd    = ~bus.step & bus.rd_start & ~w_fault;
      end
      S_SHIFT: begin
        w_do_shift = ~w_wall;
        w_set_wall = w_wall;
      end
      S_CHECK: begin
        w_set_self = w_match;
        w_idx_inc  = ~w_match & ~w_idx_last;
      end
      S_READ:  w_idx_inc = bus.rd_ready & ~w_idx_last;
      default: ;
    endcase
  end

  // Segment store, length, heading, index and sticky flags
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_heading  <= 2'd0;
      r_grow     <= 1'b0;
      r_len      <= LW'(INIT_LEN);
      r_idx      <= '0;
      r_hit_wall <= 1'b0;
      r_hit_self <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          r_seg_x[i] <= XW'(X0 - i * CELL);
          r_seg_y[i] <= YW'(Y0);
        end else begin
          r_seg_x[i] <= '0;
          r_seg_y[i] <= '0;
        end
      end
    end else begin
      if (w_accept_step) begin
        // A direct reversal keeps the current heading
        if (bus.dir != ~r_heading) r_heading <= bus.dir;
        r_grow <= bus.grow;
      end
      if (w_do_shift) begin
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
          r_seg_x[i] <= r_seg_x[i-1];
          r_seg_y[i] <= r_seg_y[i-1];
        end
        r_seg_x[0] <= w_cand_x;
        r_seg_y[0] <= w_cand_y;
        if (r_grow && (r_len < LW'(MAX_LEN))) r_len <= r_len + LW'(1);
        r_idx <= IW'(1);
      end
      if (w_set_wall) r_hit_wall <= 1'b1;
      if (w_set_self) r_hit_self <= 1'b1;
      if (w_start_rd) r_idx <= '0;
      if (w_idx_inc)  r_idx <= r_idx + IW'(1);
    end
  end

  assign bus.rd_valid = (r_state == S_READ);
  assign bus.rd_x     = r_seg_x[r_idx];
  assign bus.rd_y     = r_seg_y[r_idx];
  assign bus.rd_last  = (r_state == S_READ) && w_idx_last;
  assign bus.length   = r_len;
  assign bus.head_x   = r_seg_x[0];
  assign bus.head_y   = r_seg_y[0];
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.hit_wall = r_hit_wall;
  assign bus.hit_self = r_hit_self;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed self-checking bench for snake_body_engine.
module tb_snake_body_engine;

  logic CLOCK_50 = 1'b0;
  logic Resetn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ex [16];
  int   ey [16];

  always #10 CLOCK_50 = ~CLOCK_50;

  snake_body_engine_if #(.XW(8), .YW(7), .LW(5)) bus ();

  snake_body_engine dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(bus.busy), 0);
  endtask

  task automatic do_step(input logic [1:0] d, input logic g);
    bus.step = 1'b1;
    bus.dir  = d;
    bus.grow = g;
    tick();
    bus.step = 1'b0;
    bus.grow = 1'b0;
    check("step_busy", 32'(bus.busy), 1);
    wait_idle();
  endtask

  task automatic apply_reset();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    tick();
  endtask

  // Read n segments, rd_ready following pat[cycle%4]; compares against ex/ey
  task automatic read_pattern(input int n, input logic [3:0] pat);
    int k = 0;
    int c = 0;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    while (k < n && c < 200) begin
      bus.rd_ready = pat[c % 4];
      check("rd_valid", 32'(bus.rd_valid), 1);
      check("rd_busy",  32'(bus.busy), 1);
      check("rd_x",     32'(bus.rd_x), ex[k]);
      check("rd_y",     32'(bus.rd_y), ey[k]);
      check("rd_last",  32'(bus.rd_last), 32'(k == n - 1));
      if (bus.rd_ready) k++;
      c++;
      tick();
    end
    bus.rd_ready = 1'b0;
    check("rd_done_valid", 32'(bus.rd_valid), 0);
    check("rd_done_busy",  32'(bus.busy), 0);
  endtask

  initial begin
    Resetn       = 1'b0;
    bus.step     = 1'b0;
    bus.dir      = 2'd0;
    bus.grow     = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_len",   32'(bus.length), 4);
    check("rst_hx",    32'(bus.head_x), 80);
    check("rst_hy",    32'(bus.head_y), 30);
    check("rst_valid", 32'(bus.rd_valid), 0);
    check("rst_last",  32'(bus.rd_last), 0);
    check("rst_wall",  32'(bus.hit_wall), 0);
    check("rst_self",  32'(bus.hit_self), 0);
    Resetn = 1'b1;
    tick();

    // Initial body readout
    ex[0:3] = '{80, 70, 60, 50};
    ey[0:3] = '{30, 30, 30, 30};
    read_pattern(4, 4'b1111);

    // Grow while moving down, then a reversal request
    do_step(2'd1, 1'b1);
    check("grow_hx",  32'(bus.head_x), 80);
    check("grow_hy",  32'(bus.head_y), 40);
    check("grow_len", 32'(bus.length), 5);
    ex[0:4] = '{80, 80, 70, 60, 50};
    ey[0:4] = '{40, 30, 30, 30, 30};
    read_pattern(5, 4'b1111);
    do_step(2'd2, 1'b0);
    check("rev_hx", 32'(bus.head_x), 80);
    check("rev_hy", 32'(bus.head_y), 50);
    check("rev_self", 32'(bus.hit_self), 0);

    // Readout with stalls
    ex[0:4] = '{80, 80, 80, 70, 60};
    ey[0:4] = '{50, 40, 30, 30, 30};
    read_pattern(5, 4'b1001);

    // Reset in the middle of a readout
    bus.rd_ready = 1'b1;
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    tick();
    check("mid_rd_x", 32'(bus.rd_x), 80);
    check("mid_rd_y", 32'(bus.rd_y), 40);
    Resetn = 1'b0;
    tick();
    check("mid_rst_valid", 32'(bus.rd_valid), 0);
    check("mid_rst_busy",  32'(bus.busy), 0);
    check("mid_rst_len",   32'(bus.length), 4);
    check("mid_rst_hx",    32'(bus.head_x), 80);
    check("mid_rst_hy",    32'(bus.head_y), 30);
    Resetn = 1'b1;
    bus.rd_ready = 1'b0;
    tick();

    // step beats rd_start; left is a reversal of the reset heading
    bus.step     = 1'b1;
    bus.dir      = 2'd3;
    bus.rd_start = 1'b1;
    tick();
    bus.step     = 1'b0;
    bus.rd_start = 1'b0;
    wait_idle();
    check("prio_valid", 32'(bus.rd_valid), 0);
    check("prio_hx",    32'(bus.head_x), 90);

    // March right to the wall
    for (int x = 100; x <= 150; x += 10) begin
      do_step(2'd0, 1'b0);
      check("right_hx", 32'(bus.head_x), 32'(x));
    end
    check("pre_wall", 32'(bus.hit_wall), 0);
    do_step(2'd0, 1'b0);
    check("wall_set", 32'(bus.hit_wall), 1);
    check("wall_hx",  32'(bus.head_x), 150);
    check("wall_hy",  32'(bus.head_y), 30);
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    check("wall_step_ign", 32'(bus.busy), 0);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    check("wall_rd_ign", 32'(bus.rd_valid), 0);
    check("wall_hx2",    32'(bus.head_x), 150);
    check("wall_len",    32'(bus.length), 4);

    // Upper wall
    apply_reset();
    check("flags_clr", 32'({bus.hit_wall, bus.hit_self}), 0);
    for (int y = 20; y >= 0; y -= 10) begin
      do_step(2'd2, 1'b0);
      check("up_hy", 32'(bus.head_y), 32'(y));
    end
    check("up_pre_wall", 32'(bus.hit_wall), 0);
    do_step(2'd2, 1'b0);
    check("up_wall",  32'(bus.hit_wall), 1);
    check("up_hy0",   32'(bus.head_y), 0);
    check("up_self",  32'(bus.hit_self), 0);

    // Self collision: grow, then down, left, up onto the old body
    apply_reset();
    do_step(2'd0, 1'b1);
    check("sc_len", 32'(bus.length), 5);
    do_step(2'd1, 1'b0);
    do_step(2'd3, 1'b0);
    check("sc_pre", 32'(bus.hit_self), 0);
    bus.step = 1'b1;
    bus.dir  = 2'd2;
    tick();
    bus.step = 1'b0;
    tick();
    begin
      int n = 0;
      while (bus.busy && n < 20) begin
        tick();
        n++;
      end
      check("sc_latency", 32'(n <= 4), 1);
    end
    check("sc_self", 32'(bus.hit_self), 1);
    check("sc_wall", 32'(bus.hit_wall), 0);
    check("sc_hx",   32'(bus.head_x), 80);
    check("sc_hy",   32'(bus.head_y), 30);
    bus.step = 1'b1;
    bus.dir  = 2'd3;
    tick();
    bus.step = 1'b0;
    check("sc_step_ign", 32'(bus.busy), 0);
    check("sc_hx2",      32'(bus.head_x), 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
